// File: rtl/wb_if.sv
// wb_if: M/W pipeline inputs and GRF write-port / forwarding outputs of the writeback stage.
interface wb_if;
  logic        en;
  logic        clr;
  logic        valid_m;
  logic [31:0] pc_m;
  logic [31:0] alu_m;
  logic [31:0] dm_m;
  logic [4:0]  a3_m;
  logic        regwrite_m;
  logic [1:0]  wsel_m;
  logic [2:0]  ldtype_m;
  logic        we_w;
  logic [4:0]  a3_w;
  logic [31:0] wd_w;
  logic [31:0] pc_w;
  logic        fwd_hit_w;
  logic [31:0] retired;
  modport master (
    output en, clr, valid_m, pc_m, alu_m, dm_m, a3_m, regwrite_m, wsel_m, ldtype_m,
    input  we_w, a3_w, wd_w, pc_w, fwd_hit_w, retired
  );
  modport slave (
    input  en, clr, valid_m, pc_m, alu_m, dm_m, a3_m, regwrite_m, wsel_m, ldtype_m,
    output we_w, a3_w, wd_w, pc_w, fwd_hit_w, retired
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback stage (M/W register, load extension, writeback mux, retire counter).
// Define WB_SUBWORD_EN for lb/lbu/lh/lhu extension; otherwise every load behaves as lw.
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  wb_if.slave bus
);
  logic        valid_q, valid_d;
  logic        counted_q, counted_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dm_q, dm_d;
  logic [4:0]  a3_q, a3_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] ld_data;
  logic        load;
  assign load = bus.clr || bus.en;
  always_comb begin
    valid_d    = bus.clr ? 1'b0     : bus.en ? bus.valid_m    : valid_q;
    pc_d       = bus.clr ? PC_RESET : bus.en ? bus.pc_m       : pc_q;
    alu_d      = bus.clr ? 32'h0    : bus.en ? bus.alu_m      : alu_q;
    dm_d       = bus.clr ? 32'h0    : bus.en ? bus.dm_m       : dm_q;
    a3_d       = bus.clr ? 5'h0     : bus.en ? bus.a3_m       : a3_q;
    regwrite_d = bus.clr ? 1'b0     : bus.en ? bus.regwrite_m : regwrite_q;
    wsel_d     = bus.clr ? 2'h0     : bus.en ? bus.wsel_m     : wsel_q;
    ldtype_d   = bus.clr ? 3'h0     : bus.en ? bus.ldtype_m   : ldtype_q;
    // a held instruction keeps driving the GRF but is marked as already retired
    counted_d  = !load;
    retired_d  = retired_q + {31'h0, valid_q && !counted_q};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      counted_q  <= 1'b0;
      pc_q       <= PC_RESET;
      alu_q      <= 32'h0;
      dm_q       <= 32'h0;
      a3_q       <= 5'h0;
      regwrite_q <= 1'b0;
      wsel_q     <= 2'h0;
      ldtype_q   <= 3'h0;
      retired_q  <= 32'h0;
    end else begin
      valid_q    <= valid_d;
      counted_q  <= counted_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      dm_q       <= dm_d;
      a3_q       <= a3_d;
      regwrite_q <= regwrite_d;
      wsel_q     <= wsel_d;
      ldtype_q   <= ldtype_d;
      retired_q  <= retired_d;
    end
  end
`ifdef WB_SUBWORD_EN
  logic [31:0] byte_sh;
  logic [15:0] half;
  assign byte_sh = dm_q >> {alu_q[1:0], 3'b000};
  assign half    = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
  always_comb
    ld_data = ldtype_q == 3'd1 ? {{24{byte_sh[7]}}, byte_sh[7:0]} :
              ldtype_q == 3'd2 ? {24'h0, byte_sh[7:0]} :
              ldtype_q == 3'd3 ? {{16{half[15]}}, half} :
              ldtype_q == 3'd4 ? {16'h0, half} : dm_q;
`else
  logic unused_ldtype;
  assign unused_ldtype = ^ldtype_q;
  assign ld_data = dm_q;
`endif
  assign bus.wd_w      = wsel_q == 2'd0 ? alu_q :
                         wsel_q == 2'd1 ? ld_data :
                         wsel_q == 2'd2 ? pc_q + 32'd8 : 32'h0;
  assign bus.we_w      = regwrite_q && valid_q;
  assign bus.a3_w      = a3_q;
  assign bus.pc_w      = pc_q;
  assign bus.fwd_hit_w = bus.we_w && a3_q != 5'h0;
  assign bus.retired   = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven scoreboard bench for wb_stage plus hold/bubble/wrap/reset sequences.
module tb_wb_stage;
`ifdef WB_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  typedef struct {
    string       name;
    logic        v;
    logic [31:0] pc, alu, dm;
    logic [4:0]  a3;
    logic        rw;
    logic [1:0]  ws;
    logic [2:0]  lt;
    logic        we, fwd;
    logic [31:0] wd_sub, wd_word;
  } vec_t;
  typedef struct {
    string       name;
    logic        we, fwd;
    logic [4:0]  a3;
    logic [31:0] wd, pc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  vec_t vt[12];
  wb_if bus();
  wb_stage #(.PC_RESET(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", n, act, req);
    end
  endtask
  task automatic chk_out(input exp_t e);
    chk({e.name, ".we"}, {31'h0, bus.we_w}, {31'h0, e.we});
    chk({e.name, ".fwd"}, {31'h0, bus.fwd_hit_w}, {31'h0, e.fwd});
    chk({e.name, ".a3"}, {27'h0, bus.a3_w}, {27'h0, e.a3});
    chk({e.name, ".wd"}, bus.wd_w, e.wd);
    chk({e.name, ".pc"}, bus.pc_w, e.pc);
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, alu, dm, input logic [4:0] a3,
                       input logic rw, input logic [1:0] ws, input logic [2:0] lt);
    bus.valid_m = v; bus.pc_m = pc; bus.alu_m = alu; bus.dm_m = dm;
    bus.a3_m = a3; bus.regwrite_m = rw; bus.wsel_m = ws; bus.ldtype_m = lt;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] rexp, rb;
    logic prev_v;
    exp_t e;
    vt[0]  = '{"alu",  1, 32'h3000, 32'h1234, 32'h0, 8, 1, 0, 0, 1, 1, 32'h1234, 32'h1234};
    vt[1]  = '{"lb",   1, 32'h3004, 32'h3003, 32'h8081_7F80, 9, 1, 1, 1, 1, 1, 32'hFFFF_FF80, 32'h8081_7F80};
    vt[2]  = '{"lbu",  1, 32'h3008, 32'h3003, 32'h8081_7F80, 9, 1, 1, 2, 1, 1, 32'h0000_0080, 32'h8081_7F80};
    vt[3]  = '{"lh",   1, 32'h300C, 32'h3002, 32'h8081_7F80, 9, 1, 1, 3, 1, 1, 32'hFFFF_8081, 32'h8081_7F80};
    vt[4]  = '{"lhu",  1, 32'h3010, 32'h3001, 32'h8081_7F80, 9, 1, 1, 4, 1, 1, 32'h0000_7F80, 32'h8081_7F80};
    vt[5]  = '{"lw",   1, 32'h3014, 32'h3000, 32'h8081_7F80, 9, 1, 1, 0, 1, 1, 32'h8081_7F80, 32'h8081_7F80};
    vt[6]  = '{"lt7",  1, 32'h3018, 32'h3003, 32'h1234_5678, 9, 1, 1, 7, 1, 1, 32'h1234_5678, 32'h1234_5678};
    vt[7]  = '{"jal",  1, 32'h3010, 32'h0, 32'h0, 31, 1, 2, 0, 1, 1, 32'h3018, 32'h3018};
    vt[8]  = '{"rsv",  1, 32'h3020, 32'h55, 32'h66, 4, 1, 3, 0, 1, 1, 32'h0, 32'h0};
    vt[9]  = '{"r0",   1, 32'h3024, 32'h77, 32'h0, 0, 1, 0, 0, 1, 0, 32'h77, 32'h77};
    vt[10] = '{"inv",  0, 32'h3028, 32'h99, 32'h0, 5, 1, 0, 0, 0, 0, 32'h99, 32'h99};
    vt[11] = '{"norw", 1, 32'h302C, 32'hAB, 32'h0, 6, 0, 0, 0, 0, 0, 32'hAB, 32'hAB};
    bus.en = 1'b1; bus.clr = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_out('{"rst", 0, 0, 0, 32'h0, 32'h0});
    chk("rst.retired", bus.retired, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (5) step();
    chk_out('{"idle", 0, 0, 0, 32'h0, 32'h0});
    chk("idle.retired", bus.retired, 32'h0);
    rexp = 0; prev_v = 0;
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].pc, vt[i].alu, vt[i].dm, vt[i].a3, vt[i].rw, vt[i].ws, vt[i].lt);
      exp_q.push_back('{vt[i].name, vt[i].we, vt[i].fwd, vt[i].a3,
                        SUB ? vt[i].wd_sub : vt[i].wd_word, vt[i].pc});
      step();
      if (prev_v) rexp++;
      prev_v = vt[i].v;
      e = exp_q.pop_front();
      chk_out(e);
      chk({e.name, ".retired"}, bus.retired, rexp);
    end
    drive(1, 32'h3100, 32'hAAAA, 32'h0, 10, 1, 0, 0);
    step();
    if (prev_v) rexp++;
    rb = rexp;
    e = '{"hold", 1, 1, 10, 32'hAAAA, 32'h3100};
    drive(1, 32'h3200, 32'hBEEF, 32'h0, 3, 1, 0, 0);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out(e);
    end
    chk("hold.retired", bus.retired, rb + 32'd1);
    rexp = rb + 32'd1;
    bus.en = 1'b1; bus.clr = 1'b1;
    step();
    chk_out('{"clr_en", 0, 0, 0, 32'h0, 32'h0});
    chk("clr_en.retired", bus.retired, rexp);
    bus.clr = 1'b0;
    drive(1, 32'h3300, 32'h11, 32'h0, 12, 1, 0, 0);
    step();
    chk_out('{"pre_bub", 1, 1, 12, 32'h11, 32'h3300});
    bus.clr = 1'b1;
    step();
    chk("bub.retired", bus.retired, rexp + 32'd1);
    chk("bub.we", {31'h0, bus.we_w}, 32'h0);
    bus.clr = 1'b0;
    drive(1, 32'h3400, 32'h22, 32'h0, 13, 1, 0, 0);
    step();
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    chk("force.retired", bus.retired, 32'hFFFF_FFFF);
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    step();
    chk("wrap.retired", bus.retired, 32'h0);
    drive(1, 32'h3500, 32'h33, 32'h0, 14, 1, 0, 0);
    step();
    chk("pre_arst.we", {31'h0, bus.we_w}, 32'h1);
    #2 reset = 1'b1;
    #1 chk_out('{"arst", 0, 0, 0, 32'h0, 32'h0});
    chk("arst.retired", bus.retired, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
